// File: rtl/shift_unit_pipe_pkg.sv
// Shared types and stage-partitioning helpers for the pipelined barrel shifter.
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_t;

  function automatic int levels_per_stage(input int shamt_w, input int stages);
    return (shamt_w + stages - 1) / stages;
  endfunction

  function automatic int stage_lo(input int s, input int l);
    return s * l;
  endfunction

  // Upper bound is exclusive; stages beyond the last level get an empty range.
  function automatic int stage_hi(input int s, input int l, input int shamt_w);
    return ((s + 1) * l < shamt_w) ? (s + 1) * l : shamt_w;
  endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Request/response bus of the shift unit: valid/ready in, valid/ready out, tag sideband.
interface shift_unit_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               i_valid;
  logic               o_ready;
  logic [WIDTH-1:0]   i_data;
  logic [SHAMT_W-1:0] i_shamt;
  logic [2:0]         i_op;
  logic [TAG_W-1:0]   i_tag;
  logic               o_valid;
  logic               i_ready;
  logic [WIDTH-1:0]   o_result;
  logic [TAG_W-1:0]   o_tag;

  modport master (
    output i_valid, i_data, i_shamt, i_op, i_tag, i_ready,
    input  o_ready, o_valid, o_result, o_tag
  );

  modport slave (
    input  i_valid, i_data, i_shamt, i_op, i_tag, i_ready,
    output o_ready, o_valid, o_result, o_tag
  );
endinterface

// File: rtl/shift_unit_pipe_stage.sv
// One pipeline stage: applies shift levels LO..HI-1 to the incoming operand, then registers it.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int LO    = 0,
  parameter int HI    = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       adv_i,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic [2:0]                 op_i,
  input  logic [$clog2(WIDTH)-1:0]   shamt_i,
  input  logic                       fill_i,
  input  logic [TAG_W-1:0]           tag_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [2:0]                 op_o,
  output logic [$clog2(WIDTH)-1:0]   shamt_o,
  output logic                       fill_o,
  output logic [TAG_W-1:0]           tag_o
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic                valid_q;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [2:0]          op_q;
  logic [SHAMT_W-1:0]  shamt_q;
  logic                fill_q;
  logic [TAG_W-1:0]    tag_q;

  // SRA fills with the operand's original MSB, carried alongside rather than re-read.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [2:0] op,
                                                   input logic fill,
                                                   input int amt);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    ones = '1;
    case (op)
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = (d >> amt) | (fill ? ~(ones >> amt) : '0);
      OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
      OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    data_d = data_i;
    for (int k = LO; k < HI; k++) begin
      if (|(shamt_i & SHAMT_W'(1 << k))) begin
        data_d = shift_level(data_d, op_i, fill_i, 1 << k);
      end
    end
  end

  // Stage register boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      op_q    <= '0;
      shamt_q <= '0;
      fill_q  <= 1'b0;
      tag_q   <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      op_q    <= op_i;
      shamt_q <= shamt_i;
      fill_q  <= fill_i;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign op_o    = op_q;
  assign shamt_o = shamt_q;
  assign fill_o  = fill_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter: SHAMT_W shift levels spread over STAGES elastic register stages.
module shift_unit_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input logic              i_clk,
  input logic              i_reset,
  shift_unit_pipe_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int L       = levels_per_stage(SHAMT_W, STAGES);

  logic [WIDTH-1:0]   data_a  [STAGES+1];
  logic [2:0]         op_a    [STAGES+1];
  logic [SHAMT_W-1:0] shamt_a [STAGES+1];
  logic               fill_a  [STAGES+1];
  logic [TAG_W-1:0]   tag_a   [STAGES+1];
  logic [STAGES-1:0]  vld_q;
  logic [STAGES-1:0]  adv;

  assign data_a[0]  = bus.i_data;
  assign op_a[0]    = bus.i_op;
  assign shamt_a[0] = bus.i_shamt;
  assign fill_a[0]  = bus.i_data[WIDTH-1];
  assign tag_a[0]   = bus.i_tag;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic vld_in;
    if (s == 0) begin : g_first
      assign vld_in = bus.i_valid;
    end else begin : g_rest
      assign vld_in = vld_q[s-1];
    end

    // A stage may load when any stage from it onward has a hole, or the output drains.
    assign adv[s] = bus.i_ready | (|((~vld_q) >> s));

    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .LO    (stage_lo(s, L)),
      .HI    (stage_hi(s, L, SHAMT_W))
    ) u_stage (
      .clk_i   (i_clk),
      .rst_i   (i_reset),
      .adv_i   (adv[s]),
      .valid_i (vld_in),
      .data_i  (data_a[s]),
      .op_i    (op_a[s]),
      .shamt_i (shamt_a[s]),
      .fill_i  (fill_a[s]),
      .tag_i   (tag_a[s]),
      .valid_o (vld_q[s]),
      .data_o  (data_a[s+1]),
      .op_o    (op_a[s+1]),
      .shamt_o (shamt_a[s+1]),
      .fill_o  (fill_a[s+1]),
      .tag_o   (tag_a[s+1])
    );
  end

  assign bus.o_ready  = adv[0];
  assign bus.o_valid  = vld_q[STAGES-1];
  assign bus.o_result = data_a[STAGES];
  assign bus.o_tag    = tag_a[STAGES];

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe in three configurations: 32/2, 64/3 and 32/1.
module tb_shift_unit_pipe;
  import shifter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_unit_pipe_if #(.WIDTH(32), .TAG_W(5)) bus_a ();
  shift_unit_pipe_if #(.WIDTH(64), .TAG_W(5)) bus_b ();
  shift_unit_pipe_if #(.WIDTH(32), .TAG_W(5)) bus_c ();

  shift_unit_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut_a (.i_clk(clk), .i_reset(rst), .bus(bus_a));
  shift_unit_pipe #(.WIDTH(64), .STAGES(3), .TAG_W(5)) dut_b (.i_clk(clk), .i_reset(rst), .bus(bus_b));
  shift_unit_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(5)) dut_c (.i_clk(clk), .i_reset(rst), .bus(bus_c));

  int passed = 0;
  int total  = 0;

  function automatic logic get_valid(input int which);
    case (which)
      0:       return bus_a.o_valid;
      1:       return bus_b.o_valid;
      default: return bus_c.o_valid;
    endcase
  endfunction

  function automatic logic [63:0] get_result(input int which);
    case (which)
      0:       return {32'h0, bus_a.o_result};
      1:       return bus_b.o_result;
      default: return {32'h0, bus_c.o_result};
    endcase
  endfunction

  function automatic logic [4:0] get_tag(input int which);
    case (which)
      0:       return bus_a.o_tag;
      1:       return bus_b.o_tag;
      default: return bus_c.o_tag;
    endcase
  endfunction

  // Issue one request into an idle unit and wait (bounded) for its result.
  task automatic send(input int which, input logic [63:0] d, input int sh, input logic [2:0] op,
                      input logic [4:0] tg, output logic [63:0] res, output logic [4:0] otag,
                      output int lat);
    case (which)
      0: begin
        bus_a.i_valid = 1'b1; bus_a.i_data = d[31:0]; bus_a.i_shamt = sh[4:0];
        bus_a.i_op = op; bus_a.i_tag = tg;
      end
      1: begin
        bus_b.i_valid = 1'b1; bus_b.i_data = d; bus_b.i_shamt = sh[5:0];
        bus_b.i_op = op; bus_b.i_tag = tg;
      end
      default: begin
        bus_c.i_valid = 1'b1; bus_c.i_data = d[31:0]; bus_c.i_shamt = sh[4:0];
        bus_c.i_op = op; bus_c.i_tag = tg;
      end
    endcase
    @(posedge clk); #1;
    bus_a.i_valid = 1'b0; bus_b.i_valid = 1'b0; bus_c.i_valid = 1'b0;
    lat = 1;
    while (!get_valid(which) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = get_result(which);
    otag = get_tag(which);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (bus_a.o_valid !== 1'b0) $display("FAIL reset_o_valid: got %0b want 0", bus_a.o_valid); else passed++;
    total++; if (bus_a.o_result !== 32'h0) $display("FAIL reset_o_result: got %h want 0", bus_a.o_result); else passed++;
    total++; if (bus_a.o_tag !== 5'h0) $display("FAIL reset_o_tag: got %h want 0", bus_a.o_tag); else passed++;
    total++; if (bus_a.o_ready !== 1'b1) $display("FAIL reset_o_ready: got %0b want 1", bus_a.o_ready); else passed++;
    total++; if (bus_b.o_valid !== 1'b0) $display("FAIL reset_b_o_valid: got %0b want 0", bus_b.o_valid); else passed++;
    total++; if (bus_c.o_ready !== 1'b1) $display("FAIL reset_c_o_ready: got %0b want 1", bus_c.o_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_sra();
    logic [63:0] res; logic [4:0] tg; int lat;
    send(0, 64'h8000_00F0, 4, OP_SRA, 5'd17, res, tg, lat);
    total++; if (res[31:0] !== 32'hF800_000F) $display("FAIL sra_result: got %h want f800000f", res[31:0]); else passed++;
    total++; if (tg !== 5'd17) $display("FAIL sra_tag: got %0d want 17", tg); else passed++;
    total++; if (lat !== 2) $display("FAIL sra_latency: got %0d want 2", lat); else passed++;
  endtask

  task automatic test_rotate();
    logic [63:0] res; logic [4:0] tg; int lat;
    send(0, 64'h8000_0001, 1, OP_ROL, 5'd1, res, tg, lat);
    total++; if (res[31:0] !== 32'h0000_0003) $display("FAIL rol_result: got %h want 00000003", res[31:0]); else passed++;
    total++; if (tg !== 5'd1) $display("FAIL rol_tag: got %0d want 1", tg); else passed++;
    send(0, 64'h8000_0001, 31, OP_ROR, 5'd2, res, tg, lat);
    total++; if (res[31:0] !== 32'h0000_0003) $display("FAIL ror_result: got %h want 00000003", res[31:0]); else passed++;
    total++; if (tg !== 5'd2) $display("FAIL ror_tag: got %0d want 2", tg); else passed++;
  endtask

  task automatic test_shamt_zero();
    logic [63:0] res; logic [4:0] tg; int lat;
    logic [2:0] opv;
    for (int k = 0; k < 6; k++) begin
      opv = (k < 5) ? 3'(k) : 3'b111;
      send(0, 64'hDEAD_BEEF, (k < 5) ? 0 : 5, opv, 5'(k), res, tg, lat);
      total++;
      if (res[31:0] !== 32'hDEAD_BEEF) $display("FAIL passthru_op%0d: got %h want deadbeef", opv, res[31:0]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int got = 0; int first = -1; int gap = 0; int ready_drop = 0;
    bus_a.i_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (bus_a.o_valid) begin
        if (first < 0) first = c;
        if (c != first + got) gap++;
        if (got < 8) begin
          total++;
          if (bus_a.o_result !== (32'h1 << got)) $display("FAIL b2b_result%0d: got %h want %h", got, bus_a.o_result, 32'h1 << got);
          else passed++;
          total++;
          if (bus_a.o_tag !== 5'(got + 3)) $display("FAIL b2b_tag%0d: got %0d want %0d", got, bus_a.o_tag, got + 3);
          else passed++;
        end
        got++;
      end
      if (c < 8) begin
        bus_a.i_valid = 1'b1; bus_a.i_data = 32'h1; bus_a.i_shamt = 5'(c);
        bus_a.i_op = OP_SLL; bus_a.i_tag = 5'(c + 3);
      end else begin
        bus_a.i_valid = 1'b0;
      end
      #1;
      if (c < 8 && !bus_a.o_ready) ready_drop++;
      @(posedge clk); #1;
    end
    bus_a.i_valid = 1'b0;
    total++; if (got !== 8) $display("FAIL b2b_count: got %0d want 8", got); else passed++;
    total++; if (gap !== 0) $display("FAIL b2b_consecutive: got %0d gaps want 0", gap); else passed++;
    total++; if (ready_drop !== 0) $display("FAIL b2b_ready: got %0d drops want 0", ready_drop); else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] exp_r [4] = '{32'h7800_0000, 32'h3C00_0000, 32'h1E00_0000, 32'h0F00_0000};
    logic [31:0] held = '0; logic [4:0] held_tag = '0;
    int have_held = 0; int unstable = 0; int idx = 0; int got = 0;
    bus_a.i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus_a.o_valid) begin
        if (have_held == 0) begin
          held = bus_a.o_result; held_tag = bus_a.o_tag; have_held = 1;
        end else if (bus_a.o_result !== held || bus_a.o_tag !== held_tag) begin
          unstable++;
        end
      end
      bus_a.i_valid = 1'b1; bus_a.i_data = 32'hF000_0000; bus_a.i_shamt = 5'(idx + 1);
      bus_a.i_op = OP_SRL; bus_a.i_tag = 5'(20 + idx);
      #1;
      if (bus_a.o_ready) idx++;
      @(posedge clk); #1;
    end
    total++; if (idx !== 2) $display("FAIL stall_accepts: got %0d want 2", idx); else passed++;
    total++; if (bus_a.o_ready !== 1'b0) $display("FAIL stall_o_ready: got %0b want 0", bus_a.o_ready); else passed++;
    total++; if (have_held !== 1) $display("FAIL stall_o_valid: got %0d want 1", have_held); else passed++;
    total++; if (held !== exp_r[0]) $display("FAIL stall_held: got %h want %h", held, exp_r[0]); else passed++;
    total++; if (unstable !== 0) $display("FAIL stall_stable: got %0d changes want 0", unstable); else passed++;
    bus_a.i_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (bus_a.o_valid) begin
        total++;
        if (bus_a.o_result !== exp_r[got]) $display("FAIL stall_result%0d: got %h want %h", got, bus_a.o_result, exp_r[got]);
        else passed++;
        total++;
        if (bus_a.o_tag !== 5'(20 + got)) $display("FAIL stall_tag%0d: got %0d want %0d", got, bus_a.o_tag, 20 + got);
        else passed++;
        got++;
      end
      if (idx < 4) begin
        bus_a.i_valid = 1'b1; bus_a.i_data = 32'hF000_0000; bus_a.i_shamt = 5'(idx + 1);
        bus_a.i_op = OP_SRL; bus_a.i_tag = 5'(20 + idx);
      end else begin
        bus_a.i_valid = 1'b0;
      end
      #1;
      if (bus_a.i_valid && bus_a.o_ready) idx++;
      @(posedge clk); #1;
    end
    bus_a.i_valid = 1'b0;
    total++; if (got !== 4) $display("FAIL stall_drain_count: got %0d want 4", got); else passed++;
  endtask

  task automatic test_reset_flush();
    int stale = 0;
    bus_a.i_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus_a.i_valid = 1'b1; bus_a.i_data = 32'h0000_00FF; bus_a.i_shamt = 5'(c + 1);
      bus_a.i_op = OP_SLL; bus_a.i_tag = 5'(9 + c);
      @(posedge clk); #1;
    end
    bus_a.i_valid = 1'b0;
    total++; if (bus_a.o_valid !== 1'b1) $display("FAIL flush_inflight: got %0b want 1", bus_a.o_valid); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus_a.o_valid !== 1'b0) $display("FAIL flush_o_valid: got %0b want 0", bus_a.o_valid); else passed++;
    rst = 1'b0;
    #1;
    total++; if (bus_a.o_ready !== 1'b1) $display("FAIL flush_o_ready: got %0b want 1", bus_a.o_ready); else passed++;
    bus_a.i_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus_a.o_valid) stale++;
    end
    total++; if (stale !== 0) $display("FAIL flush_stale: got %0d results want 0", stale); else passed++;
  endtask

  task automatic test_wide();
    logic [63:0] res; logic [4:0] tg; int lat;
    send(1, 64'h1, 63, OP_SLL, 5'd4, res, tg, lat);
    total++; if (res !== 64'h8000_0000_0000_0000) $display("FAIL w64_sll: got %h want 8000000000000000", res); else passed++;
    total++; if (lat !== 3) $display("FAIL w64_latency: got %0d want 3", lat); else passed++;
    send(1, 64'h8000_0000_0000_00F0, 4, OP_SRA, 5'd5, res, tg, lat);
    total++; if (res !== 64'hF800_0000_0000_000F) $display("FAIL w64_sra4: got %h want f80000000000000f", res); else passed++;
    total++; if (tg !== 5'd5) $display("FAIL w64_tag: got %0d want 5", tg); else passed++;
    send(1, 64'h8000_0000_0000_0000, 35, OP_SRA, 5'd6, res, tg, lat);
    total++; if (res !== 64'hFFFF_FFFF_F000_0000) $display("FAIL w64_sra35: got %h want fffffffff0000000", res); else passed++;
  endtask

  task automatic test_single();
    logic [63:0] res; logic [4:0] tg; int lat;
    send(2, 64'h1, 31, OP_SLL, 5'd7, res, tg, lat);
    total++; if (res[31:0] !== 32'h8000_0000) $display("FAIL s1_sll: got %h want 80000000", res[31:0]); else passed++;
    total++; if (lat !== 1) $display("FAIL s1_latency: got %0d want 1", lat); else passed++;
    send(2, 64'h8000_00F0, 4, OP_SRA, 5'd8, res, tg, lat);
    total++; if (res[31:0] !== 32'hF800_000F) $display("FAIL s1_sra: got %h want f800000f", res[31:0]); else passed++;
    total++; if (tg !== 5'd8) $display("FAIL s1_tag: got %0d want 8", tg); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.i_valid = 1'b0; bus_a.i_ready = 1'b1; bus_a.i_data = '0; bus_a.i_shamt = '0; bus_a.i_op = '0; bus_a.i_tag = '0;
    bus_b.i_valid = 1'b0; bus_b.i_ready = 1'b1; bus_b.i_data = '0; bus_b.i_shamt = '0; bus_b.i_op = '0; bus_b.i_tag = '0;
    bus_c.i_valid = 1'b0; bus_c.i_ready = 1'b1; bus_c.i_data = '0; bus_c.i_shamt = '0; bus_c.i_op = '0; bus_c.i_tag = '0;
    test_reset();
    test_sra();
    test_rotate();
    test_shamt_zero();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_wide();
    test_single();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
